div_iter_param: RTL and testbench

//  Parametrised multi-cycle radix-2 restoring divider: WIDTH-bit signed/unsigned divide.

---
 rtl/div_iter_param_pkg.sv | 16 +
 rtl/div_iter_param.sv | 145 ++++++++++++++
 tb/tb_div_iter_param.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : div_iter_param_pkg
//  Brief   : Shared state encoding for the iterative radix-2 divider.
//  Revision: 1.0
// ============================================================================
package div_iter_param_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_iter_param.sv
`default_nettype none
// ============================================================================
//  Module  : div_iter_param
//  Brief   : Multi-cycle radix-2 restoring divider, signed/unsigned, with
//            done pulse, divide-by-zero and signed-overflow flags.
//  Revision: 1.0
// ============================================================================
module div_iter_param
    import div_iter_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               zero_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   r_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;
    logic               overflow_q;

    logic [WIDTH-1:0]   dvd_abs_d;
    logic [WIDTH-1:0]   dvs_abs_d;
    logic [WIDTH:0]     rem_sh_d;
    logic [WIDTH:0]     diff_d;

    always_comb begin
        dvd_abs_d = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs_d = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        // One extra bit on the shifted remainder makes the MSB of the
        // difference a clean borrow indicator.
        rem_sh_d  = {rem_q, quo_q[WIDTH-1]};
        diff_d    = rem_sh_d - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        qneg_q <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_q <= div_signed & dividend[WIDTH-1];
                        zero_q <= (divisor == '0);
                        ovf_q  <= div_signed && (dividend == MIN_VAL) && (divisor == '1);
                        dvs_q  <= dvs_abs_d;
                        rem_q  <= '0;
                        cnt_q  <= CNT_W'(WIDTH - 1);
                        // A zero divisor skips iteration; the raw dividend is
                        // parked in quo_q to become the remainder.
                        if (divisor == '0) begin
                            quo_q   <= dividend;
                            state_q <= DIV_FIX;
                        end else begin
                            quo_q   <= dvd_abs_d;
                            state_q <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (!diff_d[WIDTH]) begin
                        rem_q <= diff_d[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh_d[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_q <= DIV_FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DIV_FIX: begin
                    if (zero_q) begin
                        q_q <= '1;
                        r_q <= quo_q;
                    end else begin
                        q_q <= qneg_q ? -quo_q : quo_q;
                        r_q <= rneg_q ? -rem_q : rem_q;
                    end
                    div_zero_q <= zero_q;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q        = q_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter_param.sv
`default_nettype none
// ============================================================================
//  Module  : tb_div_iter_param
//  Brief   : Self-checking bench for div_iter_param against an arithmetic model.
//  Revision: 1.0
// ============================================================================
module tb_div_iter_param;

    localparam int          W       = 32;
    localparam logic [W-1:0] MIN_V  = 32'h8000_0000;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         div_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    div_iter_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .q          (q),
        .r          (r),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // C-style truncating division with the divider's defined corner cases.
    function automatic res_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t res;
        res = '0;
        if (b == '0) begin
            res.q  = '1;
            res.r  = a;
            res.dz = 1'b1;
        end else if (s && a == MIN_V && b == '1) begin
            res.q  = MIN_V;
            res.r  = '0;
            res.ov = 1'b1;
        end else if (s) begin
            res.q = $signed(a) / $signed(b);
            res.r = $signed(a) % $signed(b);
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Cycle-accurate expectation tracker and per-cycle compare.
    int   cyc = 0;
    logic pend = 1'b0;
    int   due = 0;
    res_t exp_res = '0;
    res_t hold = '0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                pend = 1'b0;
                hold = '0;
            end else if (start && !pend) begin
                pend    = 1'b1;
                exp_res = model(div_signed, dividend, divisor);
                due     = (divisor == '0) ? cyc + 1 : cyc + W + 1;
            end
            @(negedge clk);
            check("busy", {31'd0, busy}, {31'd0, pend && cyc < due});
            check("done", {31'd0, done}, {31'd0, pend && cyc == due});
            if (pend && cyc == due) begin
                hold = exp_res;
                pend = 1'b0;
            end else if (pend && cyc > due) begin
                pend = 1'b0;
            end
            check("q",        q, hold.q);
            check("r",        r, hold.r);
            check("div_zero", {31'd0, div_zero}, {31'd0, hold.dz});
            check("overflow", {31'd0, overflow}, {31'd0, hold.ov});
        end
    end

    task automatic wait_done(output int busy_cnt);
        int n;
        busy_cnt = 0;
        n = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 100 cycles");
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the done pulse.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic lit, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input int ebusy);
        int bc;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        if (lit) begin
            check("lit_q", q, eq);
            check("lit_r", r, er);
        end
        if (ebusy >= 0) check("busy_cycles", W'(bc), W'(ebusy));
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int bc;
        res_t m;
        rst = 1'b1; start = 1'b0; div_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_q", q, '0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Pin the model itself.
        m = model(1'b1, 32'hff33_3f3f, 32'hffaf_f222);
        check("model_sq", m.q, 32'h0000_0002);
        check("model_sr", m.r, 32'hFFD3_5AFB);
        m = model(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("model_neg", m.q, 32'hFFFF_FFFD);

        run_op(1'b1, 32'hff33_3f3f, 32'hffaf_f222, 1'b1, 32'h0000_0002, 32'hFFD3_5AFB, -1);
        check("t1_flags", {30'd0, div_zero, overflow}, 32'd0);
        run_op(1'b0, 32'hff33_3f3f, 32'hffaf_f222, 1'b1, 32'h0, 32'hff33_3f3f, -1);
        run_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 33);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, -1);
        run_op(1'b0, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1);
        check("t4_dz", {31'd0, div_zero}, 32'd1);
        run_op(1'b1, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1);
        run_op(1'b1, MIN_V, 32'hFFFF_FFFF, 1'b1, MIN_V, 32'd0, -1);
        check("t4_ovf", {31'd0, overflow}, 32'd1);

        // Start during CALC must be ignored.
        div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        dividend = 32'd77; divisor = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = 32'd9; divisor = 32'd9;
        wait_done(bc);
        check("ign_q", q, 32'd333);
        check("ign_r", r, 32'd1);

        // Back-to-back: start in the done cycle of the previous op.
        @(negedge clk);
        div_signed = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        check("b2b_a_q", q, 32'hFFFF_FFF5);
        div_signed = 1'b0; dividend = 32'd50; divisor = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_hold", q, 32'hFFFF_FFF5);
        wait_done(bc);
        check("b2b_b_q", q, 32'd8);
        check("b2b_b_r", r, 32'd2);

        // Reset in the middle of CALC.
        @(negedge clk);
        div_signed = 1'b0; dividend = 32'h0123_4567; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", q, '0);
        check("abort_r", r, '0);
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, 32'd1_000_000, 32'd999, 1'b1, 32'd1001, 32'd1, 33);

        // Random operands in both modes, with corner values mixed in.
        for (int i = 0; i < 240; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = b >> $urandom_range(0, 31);
                1: b = (i % 3 == 0) ? '0 : 32'hFFFF_FFFF;
                2: a = (i % 2 == 0) ? MIN_V : a >> 20;
                default: ;
            endcase
            run_op(i[0], a, b, 1'b0, '0, '0, -1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
